// File: rtl/tff_count_ctrl.sv
// Sequencing controller that makes an external bank of toggle flip-flops
// behave as a synchronous up/down counter running from a base value to a limit.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] step;

  // A cell toggles when every lower cell is 1 (up) or 0 (down): ripple-free carry.
  always_comb begin
    step[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      step[i] = step[i-1] & (dir_q ? ~q[i-1] : q[i-1]);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d = state_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    t_vec   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          limit_d = limit;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_vec   = dir_q ? ~q : q;
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (q == limit_q) begin
          state_d = S_DONE;
        end else if (!hold) begin
          t_vec = step;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The bank is being reset by the same clr, so no toggles may reach it.
    if (clr) begin
      t_vec = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (clr) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
      busy_q  <= (state_d == S_CLEAR) || (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench: behavioural TFF bank plus an arithmetic run model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tff_count_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clr, start, dir, hold, abort;
  logic [W-1:0] limit, q, t_vec;
  logic         busy, done;
  logic         pre_en;
  logic [W-1:0] pre_val;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  tff_count_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .dir   (dir),
    .limit (limit),
    .hold  (hold),
    .abort (abort),
    .q     (q),
    .t_vec (t_vec),
    .busy  (busy),
    .done  (done)
  );

  always #50 clk = ~clk;

  // Behavioural flip-flop bank, with a preload path to set arbitrary start values.
  always @(posedge clk) begin
    if (clr)         q <= '0;
    else if (pre_en) q <= pre_val;
    else             q <= q ^ t_vec;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run model: phase 0 idle, 1 clearing, 2 counting, 3 reporting; m_q is the expected bank value.
  int m_phase = 0;
  int m_q     = 0;
  int m_lim   = 0;
  bit m_dir   = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      m_phase <= 0;
      m_q     <= 0;
    end else begin
      if (pre_en) m_q <= int'(pre_val);
      case (m_phase)
        0: if (start) begin
             m_dir   <= dir;
             m_lim   <= int'(limit);
             m_phase <= 1;
           end
        1: begin
             m_q     <= m_dir ? MAXV : 0;
             m_phase <= abort ? 0 : 2;
           end
        2: if (abort)              m_phase <= 0;
           else if (m_q == m_lim)  m_phase <= 3;
           else if (!hold)         m_q <= m_dir ? m_q - 1 : m_q + 1;
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison, settled after the negedge stimulus update.
  always @(negedge clk) begin
    int exp_t;
    #1;
    if (chk_en) begin
      exp_t = 0;
      if (!clr) begin
        if (m_phase == 1)
          exp_t = m_q ^ (m_dir ? MAXV : 0);
        else if (m_phase == 2 && !abort && m_q != m_lim && !hold)
          exp_t = m_q ^ ((m_dir ? m_q - 1 : m_q + 1) & MAXV);
      end
      check("q", q, m_q);
      check("t_vec", t_vec, exp_t & MAXV);
      check("busy", busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
      check("done", done, (m_phase == 3) ? 1 : 0);
    end
  end

  // One run over a fixed 40-cycle window; k counts cycles after the start edge E0.
  task automatic run(input bit d, input int lim, input int hold_k, input int st_k,
                     input int abort_q, input int clr_q,
                     output int done_k, output int n_done, output int n_busy);
    bit fired_a = 1'b0;
    bit fired_c = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dir   = d;
    limit = lim[W-1:0];
    done_k = -1;
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = (k == st_k);
      hold  = (k >= hold_k) && (k < hold_k + 3);
      abort = 1'b0;
      clr   = 1'b0;
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (busy) n_busy++;
      if (!fired_a && k >= 1 && busy && int'(q) == abort_q) begin
        abort   = 1'b1;
        fired_a = 1'b1;
      end
      if (!fired_c && k >= 1 && busy && int'(q) == clr_q) begin
        clr     = 1'b1;
        fired_c = 1'b1;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
    clr   = 1'b0;
  endtask

  initial begin
    int dk, nd, nb;
    clr = 1'b0; start = 1'b0; dir = 1'b0; hold = 1'b0; abort = 1'b0;
    limit = '0;
    pre_en = 1'b1;
    pre_val = W'($urandom_range(1, MAXV));

    // Reset with the bank holding a random value.
    @(negedge clk);
    pre_en = 1'b0;
    clr    = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset t_vec", t_vec, 0);
    clr = 1'b0;
    #1;
    check("reset q", q, 0);
    chk_en = 1'b1;

    // Up run from a preloaded 0110 to 5.
    pre_en = 1'b1;
    pre_val = 4'b0110;
    @(negedge clk);
    pre_en = 1'b0;
    check("preload q", q, 6);
    run(1'b0, 5, 99, -1, -1, -1, dk, nd, nb);
    check("up done cycle", dk, 7);
    check("up busy cycles", nb, 7);
    check("up done count", nd, 1);
    check("up final q", q, 5);

    // Down run to 12.
    run(1'b1, 12, 99, -1, -1, -1, dk, nd, nb);
    check("down done cycle", dk, 5);
    check("down busy cycles", nb, 5);
    check("down final q", q, 12);

    // Hold for three cycles, with an ignored start pulse mid-run.
    run(1'b0, 5, 3, 4, -1, -1, dk, nd, nb);
    check("hold done cycle", dk, 10);
    check("hold busy cycles", nb, 10);
    check("hold done count", nd, 1);

    // Zero-step run.
    run(1'b0, 0, 99, -1, -1, -1, dk, nd, nb);
    check("zero done cycle", dk, 2);
    check("zero busy cycles", nb, 2);

    // Abort at q=3 of a run to 9.
    run(1'b0, 9, 99, -1, 3, -1, dk, nd, nb);
    check("abort done count", nd, 0);
    check("abort final q", q, 3);

    // Clear at q=4, then a fresh up run.
    run(1'b0, 9, 99, -1, -1, 4, dk, nd, nb);
    check("clr done count", nd, 0);
    check("clr final q", q, 0);
    check("clr final busy", busy, 0);
    run(1'b0, 5, 99, -1, -1, -1, dk, nd, nb);
    check("fresh done cycle", dk, 7);
    check("fresh busy cycles", nb, 7);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      dir   = 1'($urandom);
      limit = W'($urandom);
      hold  = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      clr   = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    start = 1'b0; hold = 1'b0; abort = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
